// File: rtl/ibex_pkg.sv
// Shared types and constants for the interrupt front-end: FSM states and exc_cause encodings.
package ibex_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE = 2'd0,
        IRQ_REQ  = 2'd1,
        IRQ_HOLD = 2'd2
    } irq_fsm_e;

    localparam logic [5:0] EXC_CAUSE_IRQ_SOFTWARE_M = 6'h23;
    localparam logic [5:0] EXC_CAUSE_IRQ_TIMER_M    = 6'h27;
    localparam logic [5:0] EXC_CAUSE_IRQ_EXTERNAL_M = 6'h2B;
    localparam logic [5:0] EXC_CAUSE_IRQ_NM         = 6'h3F;

    // Fast causes are {IRQ_FAST_CAUSE_PREFIX, fast_id}
    localparam logic [1:0] IRQ_FAST_CAUSE_PREFIX = 2'b11;

endpackage

// File: rtl/ibex_irq_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous interrupt lines; both stages reset to 0.
module ibex_irq_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt front-end: latches, masks and prioritises NMI, M-mode and fast sources behind a req/ack handshake.
// Define IBEX_IRQ_SYNC_EN to put a two-flop synchroniser on every irq_*_i input.
module ibex_irq_arbiter
    import ibex_pkg::*;
#(
    parameter int unsigned              NUM_FAST_IRQ   = 15,
    parameter logic [NUM_FAST_IRQ-1:0]  FAST_EDGE_MASK = '0,
    parameter int unsigned              FAST_ID_W      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      irq_software_i,
    input  logic                      irq_timer_i,
    input  logic                      irq_external_i,
    input  logic [NUM_FAST_IRQ-1:0]   irq_fast_i,
    input  logic                      irq_nm_i,
    input  logic                      csr_mstatus_mie_i,
    input  logic [NUM_FAST_IRQ+2:0]   csr_mie_i,
    input  logic                      debug_mode_i,
    input  logic                      mret_i,
    input  logic                      irq_ack_i,
    output logic                      irq_req_o,
    output logic [5:0]                irq_cause_o,
    output logic                      irq_pending_o,
    output logic                      nmi_mode_o,
    output logic [NUM_FAST_IRQ+2:0]   csr_mip_o,
    output logic [1:0]                irq_fsm_o
);

    localparam int unsigned NIN = NUM_FAST_IRQ + 4;

    // Handshake: irq_req_o/irq_cause_o are registered and stay stable while irq_req_o = 1;
    // a request is taken on any cycle where irq_req_o & irq_ack_i, and may be withdrawn
    // (irq_req_o drops without ack) when it is no longer eligible.

    logic [NIN-1:0] irq_raw;
    logic [NIN-1:0] irq_in;

    assign irq_raw = {irq_nm_i, irq_fast_i, irq_external_i, irq_timer_i, irq_software_i};

`ifdef IBEX_IRQ_SYNC_EN
    ibex_irq_sync #(
        .WIDTH (NIN)
    ) u_irq_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (irq_raw),
        .q_o    (irq_in)
    );
`else
    assign irq_in = irq_raw;
`endif

    logic                    sw_in;
    logic                    tmr_in;
    logic                    ext_in;
    logic                    nm_in;
    logic [NUM_FAST_IRQ-1:0] fast_in;

    assign {nm_in, fast_in, ext_in, tmr_in, sw_in} = irq_in;

    irq_fsm_e                state_q;
    logic                    req_q;
    logic [5:0]              cause_q;
    logic                    cause_nmi_q;
    logic                    nmi_mode_q;
    logic [NUM_FAST_IRQ-1:0] prev_q;
    logic [NUM_FAST_IRQ-1:0] latch_q;
    logic [NUM_FAST_IRQ-1:0] latch_clr;
    logic [NUM_FAST_IRQ-1:0] fast_pend;
    logic [NUM_FAST_IRQ+2:0] enabled;
    logic                    nmi_ok;
    logic                    mask_ok;
    logic                    elig;
    logic                    req_ack;
    logic [5:0]              win_cause;
    logic                    win_nmi;

    assign req_ack   = (state_q == IRQ_REQ) & irq_ack_i;
    assign fast_pend = (FAST_EDGE_MASK & latch_q) | (~FAST_EDGE_MASK & fast_in);
    assign csr_mip_o = {fast_pend, ext_in, tmr_in, sw_in};
    assign enabled   = csr_mip_o & csr_mie_i;

    assign nmi_ok        = nm_in & ~nmi_mode_q;
    assign mask_ok       = (|enabled) & csr_mstatus_mie_i;
    assign elig          = ~debug_mode_i & (nmi_ok | mask_ok);
    assign irq_pending_o = (|enabled) | nm_in;

    // A taken fast request clears its own latch; cause_nmi_q keeps fast id 15 distinct from NMI.
    always_comb begin
        latch_clr = '0;
        if (req_ack && !cause_nmi_q && (cause_q[5:4] == IRQ_FAST_CAUSE_PREFIX)) begin
            for (int i = 0; i < NUM_FAST_IRQ; i++) begin
                if (cause_q[FAST_ID_W-1:0] == FAST_ID_W'(i)) begin
                    latch_clr[i] = 1'b1;
                end
            end
        end
    end

    // Lowest priority first so later assignments override; the ascending fast loop leaves the highest index.
    always_comb begin
        win_cause = '0;
        win_nmi   = 1'b0;
        if (nmi_ok) begin
            win_cause = EXC_CAUSE_IRQ_NM;
            win_nmi   = 1'b1;
        end else if (mask_ok) begin
            if (enabled[1]) win_cause = EXC_CAUSE_IRQ_TIMER_M;
            if (enabled[0]) win_cause = EXC_CAUSE_IRQ_SOFTWARE_M;
            if (enabled[2]) win_cause = EXC_CAUSE_IRQ_EXTERNAL_M;
            for (int i = 0; i < NUM_FAST_IRQ; i++) begin
                if (enabled[3+i]) win_cause = {IRQ_FAST_CAUSE_PREFIX, FAST_ID_W'(i)};
            end
        end
    end

    // Set wins over a simultaneous ack clear so a fresh edge is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q  <= '0;
            latch_q <= '0;
        end else begin
            prev_q  <= fast_in;
            latch_q <= ((latch_q & ~latch_clr) | (fast_in & ~prev_q)) & FAST_EDGE_MASK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IRQ_IDLE;
            req_q       <= 1'b0;
            cause_q     <= '0;
            cause_nmi_q <= 1'b0;
            nmi_mode_q  <= 1'b0;
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (elig) begin
                        state_q     <= IRQ_REQ;
                        req_q       <= 1'b1;
                        cause_q     <= win_cause;
                        cause_nmi_q <= win_nmi;
                    end
                end
                IRQ_REQ: begin
                    if (irq_ack_i) begin
                        state_q <= IRQ_HOLD;
                        req_q   <= 1'b0;
                    end else if (!elig) begin
                        state_q <= IRQ_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                IRQ_HOLD: begin
                    state_q <= IRQ_IDLE;
                    req_q   <= 1'b0;
                end
                default: begin
                    state_q <= IRQ_IDLE;
                    req_q   <= 1'b0;
                end
            endcase

            if (req_ack && cause_nmi_q) begin
                nmi_mode_q <= 1'b1;
            end else if (mret_i) begin
                nmi_mode_q <= 1'b0;
            end
        end
    end

    assign irq_req_o   = req_q;
    assign irq_cause_o = cause_q;
    assign nmi_mode_o  = nmi_mode_q;
    assign irq_fsm_o   = state_q;

endmodule

// File: tb/tb_ibex_irq_arbiter.sv
// Bench for ibex_irq_arbiter: directed handshake scenarios plus randomized traffic against a behavioural model.
module tb_ibex_irq_arbiter;

    localparam int N = 16;
    localparam int W = N + 3;
    localparam int EW = W + 11;
    localparam logic [N-1:0] EDGE = 16'h0A0B;
`ifdef IBEX_IRQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sw = 0, tmr = 0, ext = 0, nm = 0, mst = 0, dbg = 0, mret = 0, ack = 0;
    logic [N-1:0] fast = '0;
    logic [W-1:0] mie = '0;

    logic         req_o, pend_o, nmi_o;
    logic [5:0]   cause_o;
    logic [W-1:0] mip_o;
    logic [1:0]   fsm_o;

    int n_checks = 0;
    int n_fail = 0;

    logic [EW-1:0] exp_q[$];

    ibex_irq_arbiter #(
        .NUM_FAST_IRQ   (N),
        .FAST_EDGE_MASK (EDGE),
        .FAST_ID_W      (4)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .irq_software_i    (sw),
        .irq_timer_i       (tmr),
        .irq_external_i    (ext),
        .irq_fast_i        (fast),
        .irq_nm_i          (nm),
        .csr_mstatus_mie_i (mst),
        .csr_mie_i         (mie),
        .debug_mode_i      (dbg),
        .mret_i            (mret),
        .irq_ack_i         (ack),
        .irq_req_o         (req_o),
        .irq_cause_o       (cause_o),
        .irq_pending_o     (pend_o),
        .nmi_mode_o        (nmi_o),
        .csr_mip_o         (mip_o),
        .irq_fsm_o         (fsm_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int           m_phase;     // 0 idle, 1 requesting, 2 one-cycle gap after ack
    logic [5:0]   m_cause;
    bit           m_is_nmi;
    bit           m_nmi_mode;
    bit [N-1:0]   m_latch;
    bit [N-1:0]   m_prev;
    logic [N+3:0] m_s1, m_s2;

    function automatic logic [N+3:0] raw_vec();
        return {nm, fast, ext, tmr, sw};
    endfunction

    function automatic logic [N+3:0] eff_vec();
`ifdef IBEX_IRQ_SYNC_EN
        return m_s2;
`else
        return raw_vec();
`endif
    endfunction

    function automatic logic [W-1:0] m_mip(input logic [N+3:0] v, input bit [N-1:0] lat);
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = EDGE[i] ? lat[i] : v[3+i];
        return {p, v[2], v[1], v[0]};
    endfunction

    function automatic logic [6:0] m_win(input logic [N+3:0] v, input logic [W-1:0] en,
                                         input bit mst_v, input bit nmode);
        if (v[N+3] && !nmode) return {1'b1, 6'h3F};
        if (mst_v) begin
            for (int i = N - 1; i >= 0; i--) if (en[3+i]) return {1'b0, 6'(48 + i)};
            if (en[2]) return {1'b0, 6'h2B};
            if (en[0]) return {1'b0, 6'h23};
            if (en[1]) return {1'b0, 6'h27};
        end
        return '0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [N+3:0] v;
        logic [W-1:0] en;
        logic [6:0]   w;
        bit           elig;
        int           clr;
        bit           set_nmi;
        bit [N-1:0]   nlat;
        if (!rst_n) begin
            m_phase    <= 0;
            m_cause    <= '0;
            m_is_nmi   <= 1'b0;
            m_nmi_mode <= 1'b0;
            m_latch    <= '0;
            m_prev     <= '0;
            m_s1       <= '0;
            m_s2       <= '0;
        end else begin
            v    = eff_vec();
            en   = m_mip(v, m_latch) & mie;
            w    = m_win(v, en, mst, m_nmi_mode);
            elig = !dbg && ((v[N+3] && !m_nmi_mode) || (mst && (en != 0)));
            clr  = -1;
            set_nmi = 1'b0;
            if (m_phase == 0) begin
                if (elig) begin
                    m_phase  <= 1;
                    m_cause  <= w[5:0];
                    m_is_nmi <= w[6];
                end
            end else if (m_phase == 1) begin
                if (ack) begin
                    m_phase <= 2;
                    if (m_is_nmi) set_nmi = 1'b1;
                    else if (m_cause >= 6'h30) clr = int'(m_cause) - 48;
                end else if (!elig) begin
                    m_phase <= 0;
                end
            end else begin
                m_phase <= 0;
            end
            nlat = m_latch;
            for (int i = 0; i < N; i++) begin
                if (EDGE[i]) begin
                    if (v[3+i] && !m_prev[i]) nlat[i] = 1'b1;
                    else if (clr == i) nlat[i] = 1'b0;
                end
            end
            m_latch <= nlat;
            m_prev  <= v[3 +: N];
            if (set_nmi) m_nmi_mode <= 1'b1;
            else if (mret) m_nmi_mode <= 1'b0;
            m_s2 <= m_s1;
            m_s1 <= raw_vec();
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [N+3:0]  v;
        logic [W-1:0]  mip_e;
        logic [EW-1:0] e;
        if (rst_n) begin
            v     = eff_vec();
            mip_e = m_mip(v, m_latch);
            exp_q.push_back({2'(m_phase), (m_phase == 1), m_cause, m_nmi_mode,
                             ((mip_e & mie) != 0) || v[N+3], mip_e});
            e = exp_q.pop_front();
            check("model_fsm", 32'(fsm_o), 32'(e[EW-1 -: 2]));
            check("model_req", 32'(req_o), 32'(e[W+8]));
            if (e[W+8]) check("model_cause", 32'(cause_o), 32'(e[W+7 -: 6]));
            check("model_nmi_mode", 32'(nmi_o), 32'(e[W+1]));
            check("model_pending", 32'(pend_o), 32'(e[W]));
            check("model_mip", 32'(mip_o), 32'(e[W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        sw = 0; tmr = 0; ext = 0; nm = 0; mst = 0; dbg = 0; mret = 0; ack = 0;
        fast = '0; mie = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("reset_req", 32'(req_o), 32'h0);
        check("reset_cause", 32'(cause_o), 32'h0);
        check("reset_nmi_mode", 32'(nmi_o), 32'h0);
        check("reset_fsm", 32'(fsm_o), 32'h0);
        check("reset_mip", 32'(mip_o), 32'h0);
    endtask

    // Waits (bounded) for irq_req_o, checks the cause and returns the number of cycles waited.
    task automatic wait_req(input string name, input logic [5:0] exp_cause, output int cycles);
        cycles = 0;
        while (!req_o && cycles < 20) begin
            tick();
            cycles++;
        end
        check({name, "_req"}, 32'(req_o), 32'h1);
        if (req_o) check({name, "_cause"}, 32'(cause_o), 32'(exp_cause));
    endtask

    task automatic pulse_fast(input int idx);
        fast[idx] = 1'b1;
        tick();
        fast[idx] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  cyc;
        bit  saw;
        logic [N-1:0] flip;

        // Test 1: timer + external, external wins, timer follows after the gap.
        do_reset();
        mst = 1; mie = '1;
        tmr = 1; ext = 1;
        cyc = 0;
        while (!req_o && cyc < 10) begin
            tick();
            cyc++;
        end
        check("t1_latency", 32'(cyc), 32'(LAT));
        check("t1_cause", 32'(cause_o), 32'h2B);
        ack = 1; ext = 0;
        tick();
        ack = 0;
        check("t1_hold_req", 32'(req_o), 32'h0);
        check("t1_hold_fsm", 32'(fsm_o), 32'h2);
        wait_req("t1_timer", 6'h27, cyc);
        check("t1_gap", 32'(cyc), 32'h2);

        // Test 2: single pulse on edge source 3.
        do_reset();
        mst = 1; mie = '1;
        pulse_fast(3);
        wait_req("t2_first", 6'h33, cyc);
        repeat (3) tick();
        check("t2_held_req", 32'(req_o), 32'h1);
        check("t2_held_cause", 32'(cause_o), 32'h33);
        ack = 1;
        tick();
        ack = 0;
        saw = 0;
        repeat (6) begin
            tick();
            if (req_o) saw = 1;
        end
        check("t2_no_second_req", 32'(saw), 32'h0);
        check("t2_latch_cleared", 32'(mip_o[6]), 32'h0);

        // Test 3: NMI with MIE clear, blocked while in NMI mode, re-requested after mret.
        do_reset();
        nm = 1;
        wait_req("t3_nmi", 6'h3F, cyc);
        ack = 1;
        tick();
        ack = 0;
        repeat (4) tick();
        check("t3_nmi_mode", 32'(nmi_o), 32'h1);
        check("t3_blocked", 32'(req_o), 32'h0);
        mret = 1;
        tick();
        mret = 0;
        check("t3_mret_clear", 32'(nmi_o), 32'h0);
        wait_req("t3_nmi_again", 6'h3F, cyc);

        // Test 4: withdrawal by MIE drop and by debug entry.
        do_reset();
        mst = 1; mie = '1; sw = 1;
        wait_req("t4_sw", 6'h23, cyc);
        mst = 0;
        tick();
        check("t4_mie_req", 32'(req_o), 32'h0);
        check("t4_mie_fsm", 32'(fsm_o), 32'h0);
        mst = 1;
        wait_req("t4_sw_again", 6'h23, cyc);
        dbg = 1;
        tick();
        check("t4_dbg_req", 32'(req_o), 32'h0);
        check("t4_dbg_fsm", 32'(fsm_o), 32'h0);
        dbg = 0;

        // Test 5: new edge on the same source lands in the ack cycle.
        do_reset();
        mst = 1; mie = '1;
        pulse_fast(3);
        wait_req("t5_first", 6'h33, cyc);
        fast[3] = 1'b1;
        repeat (LAT - 1) tick();
        ack = 1;
        tick();
        ack = 0;
        fast[3] = 1'b0;
        check("t5_hold_req", 32'(req_o), 32'h0);
        check("t5_latch_kept", 32'(mip_o[6]), 32'h1);
        wait_req("t5_again", 6'h33, cyc);
        check("t5_gap", 32'(cyc), 32'h2);

        // Test 6: asynchronous reset while requesting with NMI mode and a latch set.
        do_reset();
        mst = 1; mie = '1; nm = 1;
        wait_req("t6_nmi", 6'h3F, cyc);
        ack = 1;
        tick();
        ack = 0;
        pulse_fast(3);
        wait_req("t6_fast", 6'h33, cyc);
        check("t6_pre_nmi_mode", 32'(nmi_o), 32'h1);
        check("t6_pre_latch", 32'(mip_o[6]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", 32'(req_o), 32'h0);
        check("t6_async_nmi_mode", 32'(nmi_o), 32'h0);
        check("t6_async_latch", 32'(mip_o[6]), 32'h0);
        check("t6_async_fsm", 32'(fsm_o), 32'h0);
        do_reset();

        // Randomized traffic, checked every cycle by the model compare.
        mst = 1; mie = W'($urandom);
        for (int c = 0; c < 1500; c++) begin
            if (c % 50 == 0) mie = W'($urandom);
            if ($urandom_range(0, 7) == 0) sw = ~sw;
            if ($urandom_range(0, 7) == 0) tmr = ~tmr;
            if ($urandom_range(0, 7) == 0) ext = ~ext;
            if ($urandom_range(0, 19) == 0) nm = ~nm;
            flip = N'($urandom & $urandom & $urandom);
            fast = fast ^ flip;
            mst  = ($urandom_range(0, 7) != 0);
            dbg  = ($urandom_range(0, 31) == 0);
            mret = ($urandom_range(0, 15) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            tick();
        end
        clear_inputs();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
